// File: rtl/inst_mem_sync.sv
// Synchronous instruction memory for PipelineCPU.
// - Registered fetch port (1-cycle latency) with stall hold.
// - Streaming valid/ready program-load port; fetch is blocked while loading.
// - Optional macro INSTMEM_RANGE_CHECK_EN adds the AddrFault output, which
//   flags misaligned and out-of-range fetches.
// ADDR_WIDTH must exceed DEPTH_LOG2+2 so that upper address bits exist.
module inst_mem_sync #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH_LOG2 = 9,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0,
    parameter string                 INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  FetchEn,
    input  logic                  Stall,
    input  logic [ADDR_WIDTH-1:0] ReadAddr,
    output logic [DATA_WIDTH-1:0] ReadInst,
    output logic                  InstValid,
    input  logic                  ProgStart,
    input  logic [ADDR_WIDTH-1:0] ProgBase,
    input  logic                  ProgValid,
    input  logic [DATA_WIDTH-1:0] ProgData,
    input  logic                  ProgLast,
    output logic                  ProgReady,
    output logic                  Busy,
`ifdef INSTMEM_RANGE_CHECK_EN
    output logic                  AddrFault,
`endif
    output logic [DEPTH_LOG2:0]   ProgCount
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    // Count value on the beat that fills the whole array.
    localparam logic [DEPTH_LOG2:0] CountFull = (DEPTH_LOG2 + 1)'(Depth - 1);

    typedef enum logic [1:0] {StRun, StLoad, StDrain} state_e;

    logic [DATA_WIDTH-1:0] mem [Depth];

    state_e                state_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2:0]   prog_count_q;
    logic                  inst_valid_q;
    // When clear, ReadInst shows NOP_WORD instead of the RAM output register.
    logic                  inst_sel_q;
    logic                  prog_ready_q;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic [DEPTH_LOG2-1:0] fetch_idx;
    logic [DEPTH_LOG2-1:0] base_idx;
    logic                  beat;
    logic                  fetch_take;
    logic                  fault_now;
    logic                  unused_bits;

    assign fetch_idx = ReadAddr[DEPTH_LOG2+1:2];
    assign base_idx  = ProgBase[DEPTH_LOG2+1:2];

    // prog_ready_q is only ever set in StLoad, so it qualifies the beat alone.
    assign beat       = ProgValid & prog_ready_q;
    assign fetch_take = (state_q == StRun) & ~ProgStart & ~Stall & FetchEn;

`ifdef INSTMEM_RANGE_CHECK_EN
    assign fault_now = (|ReadAddr[1:0]) | (|ReadAddr[ADDR_WIDTH-1:DEPTH_LOG2+2]);
`else
    assign fault_now = 1'b0;
`endif

    // Address bits outside the word index alias away in the default build.
    assign unused_bits = ^{ReadAddr[1:0], ReadAddr[ADDR_WIDTH-1:DEPTH_LOG2+2],
                           ProgBase[1:0], ProgBase[ADDR_WIDTH-1:DEPTH_LOG2+2]};

    // RAM write port: one word per accepted load beat.
    always_ff @(posedge clk) begin
        if (beat) begin
            mem[wr_ptr_q] <= ProgData;
        end
    end

    // RAM read port: output register only advances on an accepted fetch, so it holds on stall.
    always_ff @(posedge clk) begin
        if (fetch_take) begin
            rd_data_q <= mem[fetch_idx];
        end
    end

    // Control FSM with registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StRun;
            wr_ptr_q     <= '0;
            prog_count_q <= '0;
            inst_valid_q <= 1'b0;
            inst_sel_q   <= 1'b0;
            prog_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (ProgStart) begin
                        state_q      <= StLoad;
                        wr_ptr_q     <= base_idx;
                        prog_count_q <= '0;
                        inst_valid_q <= 1'b0;
                        inst_sel_q   <= 1'b0;
                        prog_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end else if (Stall) begin
                        inst_valid_q <= inst_valid_q;
                        inst_sel_q   <= inst_sel_q;
                    end else if (FetchEn) begin
                        inst_valid_q <= 1'b1;
                        inst_sel_q   <= ~fault_now;
                    end else begin
                        inst_valid_q <= 1'b0;
                        inst_sel_q   <= 1'b0;
                    end
                end
                StLoad: begin
                    if (beat) begin
                        wr_ptr_q     <= wr_ptr_q + 1'b1;
                        prog_count_q <= prog_count_q + 1'b1;
                        if (ProgLast || (prog_count_q == CountFull)) begin
                            state_q      <= StDrain;
                            prog_ready_q <= 1'b0;
                        end
                    end
                end
                StDrain: begin
                    // One idle cycle so the final write lands before any fetch.
                    state_q      <= StRun;
                    busy_q       <= 1'b0;
                    inst_valid_q <= 1'b0;
                    inst_sel_q   <= 1'b0;
                end
                default: begin
                    state_q      <= StRun;
                    prog_ready_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

`ifdef INSTMEM_RANGE_CHECK_EN
    logic addr_fault_q;

    // Fault flag follows the same load/hold/clear rules as InstValid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_fault_q <= 1'b0;
        end else if (state_q == StRun) begin
            if (ProgStart) begin
                addr_fault_q <= 1'b0;
            end else if (!Stall) begin
                addr_fault_q <= FetchEn & fault_now;
            end
        end else begin
            addr_fault_q <= 1'b0;
        end
    end

    assign AddrFault = addr_fault_q;
`endif

    assign ReadInst  = inst_sel_q ? rd_data_q : NOP_WORD;
    assign InstValid = inst_valid_q;
    assign ProgReady = prog_ready_q;
    assign Busy      = busy_q;
    assign ProgCount = prog_count_q;

endmodule
